gpu_clut_cache_ctrl: RTL and testbench

Multi-slot CLUT tag/fill controller for the GPU texture path, successor to the single-entry CLUT manager. It holds SLOTS independent palette tags and answers a CLUT lookup from the primitive setup stage with either an immediate hit or a packet-by-packet fill. Fills are driven over a req/ack handshake to the VRAM read arbiter, and each packet write is steered into the selected palette RAM slot. The palette RAM and data path sit outside this block; it issues addresses, slot and block indices only.

---
 rtl/gpu_clut_cache_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_gpu_clut_cache_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_clut_cache_ctrl.sv
// rtl/gpu_clut_cache_ctrl.sv - multi-slot CLUT tag/fill controller; define GPU_CLUT_LRU_EN for true-LRU replacement (round-robin otherwise)
module gpu_clut_cache_ctrl #(
    parameter int SLOTS = 4,
    parameter int PKT8  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_nrstGPU,
    input  logic                     i_clutReq,
    input  logic [14:0]              i_clutAdr,
    input  logic                     i_clutIs8BPP,
    input  logic                     i_flush,
    output logic                     o_clutAck,
    output logic [$clog2(SLOTS)-1:0] o_clutSlot,
    output logic                     o_memReq,
    output logic [14:0]              o_memAdr,
    input  logic                     i_memAck,
    output logic [$clog2(SLOTS)-1:0] o_wrSlot,
    output logic [$clog2(PKT8)-1:0]  o_wrBlock,
    output logic                     o_loading
);

    localparam int SLOT_W = $clog2(SLOTS);
    localparam int BLK_W  = $clog2(PKT8);
    localparam logic [BLK_W-1:0] LAST8 = BLK_W'(PKT8 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ABORT = 2'd2,
        DONE  = 2'd3
    } clutState_t;

    clutState_t state;
    clutState_t nextState;

    // Tag store
    logic [SLOTS-1:0] tagValid;
    logic [14:0]      tagAdr [SLOTS];
    logic [SLOTS-1:0] tagIs8;

    // Current request / fill context
    logic [SLOT_W-1:0] curSlot;
    logic [14:0]       curAdr;
    logic              curIs8;
    logic [BLK_W-1:0]  block;

    logic              hitAny;
    logic [SLOT_W-1:0] hitSlot;
    logic              invAny;
    logic [SLOT_W-1:0] invSlot;
    logic [SLOT_W-1:0] policySlot;
    logic [SLOT_W-1:0] victimSlot;
    logic              lookup;
    logic              hitTake;
    logic              missStart;
    logic              lastBlock;
    logic              fillDone;
    logic [5:0]        xSum;

    // Tag compare; a 4bpp request may use an 8bpp slot, lowest matching slot wins
    always_comb begin
        hitAny  = 1'b0;
        hitSlot = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (tagValid[i] && (tagAdr[i] == i_clutAdr) && (tagIs8[i] || !i_clutIs8BPP)) begin
                hitAny  = 1'b1;
                hitSlot = SLOT_W'(i);
            end
        end
    end

    // Lowest-index invalid slot is always preferred as victim
    always_comb begin
        invAny  = 1'b0;
        invSlot = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!tagValid[i]) begin
                invAny  = 1'b1;
                invSlot = SLOT_W'(i);
            end
        end
    end

    assign victimSlot = invAny ? invSlot : policySlot;
    assign lookup     = (state == IDLE) && i_clutReq && !i_flush;
    assign hitTake    = lookup && hitAny;
    assign missStart  = lookup && !hitAny;
    assign lastBlock  = curIs8 ? (block == LAST8) : (block == '0);
    assign fillDone   = (state == LOAD) && i_memAck && lastBlock && !i_flush;

`ifdef GPU_CLUT_LRU_EN
    // Ages form a permutation: 0 is the oldest slot, SLOTS-1 the newest
    logic [SLOT_W-1:0] age [SLOTS];
    logic              touchEn;
    logic [SLOT_W-1:0] touchSlot;

    assign touchEn   = hitTake || fillDone;
    assign touchSlot = hitTake ? hitSlot : curSlot;

    // Oldest slot is the replacement candidate
    always_comb begin
        policySlot = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (age[i] == '0) begin
                policySlot = SLOT_W'(i);
            end
        end
    end

    // Touched slot becomes newest; slots that were younger than it age by one
    always_ff @(posedge i_clk or negedge i_nrstGPU) begin
        if (!i_nrstGPU) begin
            for (int i = 0; i < SLOTS; i++) begin
                age[i] <= SLOT_W'(i);
            end
        end else if (touchEn) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (SLOT_W'(i) == touchSlot) begin
                    age[i] <= SLOT_W'(SLOTS - 1);
                end else if (age[i] > age[touchSlot]) begin
                    age[i] <= age[i] - SLOT_W'(1);
                end
            end
        end
    end
`else
    logic [SLOT_W-1:0] rrPtr;

    assign policySlot = rrPtr;

    // Round-robin pointer steps on every fill start, hits leave it alone
    always_ff @(posedge i_clk or negedge i_nrstGPU) begin
        if (!i_nrstGPU) begin
            rrPtr <= '0;
        end else if (missStart) begin
            rrPtr <= rrPtr + SLOT_W'(1);
        end
    end
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_nrstGPU) begin
        if (!i_nrstGPU) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; flush in LOAD abandons the fill once the open packet is acked
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (i_clutReq && !i_flush) begin
                    nextState = hitAny ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (i_flush) begin
                    nextState = i_memAck ? IDLE : ABORT;
                end else if (i_memAck && lastBlock) begin
                    nextState = DONE;
                end
            end
            ABORT: begin
                if (i_memAck) begin
                    nextState = IDLE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Output decode from state only
    always_comb begin
        o_clutAck = 1'b0;
        o_memReq  = 1'b0;
        o_loading = 1'b0;
        case (state)
            LOAD: begin
                o_memReq  = 1'b1;
                o_loading = 1'b1;
            end
            ABORT: begin
                o_memReq = 1'b1;
            end
            DONE: begin
                o_clutAck = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Request context and packet counter; block holds still while a packet is outstanding
    always_ff @(posedge i_clk or negedge i_nrstGPU) begin
        if (!i_nrstGPU) begin
            curSlot <= '0;
            curAdr  <= '0;
            curIs8  <= 1'b0;
            block   <= '0;
        end else if (hitTake) begin
            curSlot <= hitSlot;
        end else if (missStart) begin
            curSlot <= victimSlot;
            curAdr  <= i_clutAdr;
            curIs8  <= i_clutIs8BPP;
            block   <= '0;
        end else if ((state == LOAD) && i_memAck && !lastBlock) begin
            block <= block + BLK_W'(1);
        end
    end

    // Tag store update; flush overrides any same-cycle tag write
    always_ff @(posedge i_clk or negedge i_nrstGPU) begin
        if (!i_nrstGPU) begin
            tagValid <= '0;
            tagIs8   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tagAdr[i] <= '0;
            end
        end else begin
            if (missStart) begin
                tagValid[victimSlot] <= 1'b0;
            end
            if (fillDone) begin
                tagValid[curSlot] <= 1'b1;
                tagAdr[curSlot]   <= curAdr;
                tagIs8[curSlot]   <= curIs8;
            end
            if (i_flush) begin
                tagValid <= '0;
            end
        end
    end

    assign o_clutSlot = curSlot;
    assign o_wrSlot   = curSlot;
    assign o_wrBlock  = block;
    assign xSum       = curAdr[5:0] + 6'(block);
    assign o_memAdr   = {curAdr[14:6], xSum};

endmodule

// File: tb/tb_gpu_clut_cache_ctrl.sv
// tb/tb_gpu_clut_cache_ctrl.sv - randomized self-checking bench for gpu_clut_cache_ctrl with a tag/LRU reference model
module tb_gpu_clut_cache_ctrl;

    localparam int SLOTS = 4;
    localparam int PKT8  = 16;

    logic        i_clk = 1'b0;
    logic        i_nrstGPU = 1'b0;
    logic        i_clutReq = 1'b0;
    logic [14:0] i_clutAdr = '0;
    logic        i_clutIs8BPP = 1'b0;
    logic        i_flush = 1'b0;
    logic        o_clutAck;
    logic [1:0]  o_clutSlot;
    logic        o_memReq;
    logic [14:0] o_memAdr;
    logic        i_memAck = 1'b0;
    logic [1:0]  o_wrSlot;
    logic [3:0]  o_wrBlock;
    logic        o_loading;

    int nChecks = 0;
    int nFails  = 0;

    gpu_clut_cache_ctrl #(.SLOTS(SLOTS), .PKT8(PKT8)) dut (
        .i_clk       (i_clk),
        .i_nrstGPU   (i_nrstGPU),
        .i_clutReq   (i_clutReq),
        .i_clutAdr   (i_clutAdr),
        .i_clutIs8BPP(i_clutIs8BPP),
        .i_flush     (i_flush),
        .o_clutAck   (o_clutAck),
        .o_clutSlot  (o_clutSlot),
        .o_memReq    (o_memReq),
        .o_memAdr    (o_memAdr),
        .i_memAck    (i_memAck),
        .o_wrSlot    (o_wrSlot),
        .o_wrBlock   (o_wrBlock),
        .o_loading   (o_loading)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: tags plus a recency queue (front = oldest)
    bit mValid [SLOTS];
    int mAdr   [SLOTS];
    bit mIs8   [SLOTS];
    int lruQ   [$];
    int rrPtr;

    task automatic checkEq(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs != exp) begin
            nFails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    function automatic void mReset();
        lruQ.delete();
        for (int i = 0; i < SLOTS; i++) begin
            mValid[i] = 1'b0;
            lruQ.push_back(i);
        end
        rrPtr = 0;
    endfunction

    function automatic void mFlush();
        for (int i = 0; i < SLOTS; i++) mValid[i] = 1'b0;
    endfunction

    function automatic void mTouch(int s);
        for (int i = 0; i < lruQ.size(); i++) begin
            if (lruQ[i] == s) begin
                lruQ.delete(i);
                break;
            end
        end
        lruQ.push_back(s);
    endfunction

    function automatic int mFindHit(int adr, bit is8);
        for (int i = 0; i < SLOTS; i++) begin
            if (mValid[i] && mAdr[i] == adr && (mIs8[i] || !is8)) return i;
        end
        return -1;
    endfunction

    function automatic int mStartFill();
        int v = -1;
        for (int i = 0; i < SLOTS; i++) begin
            if (!mValid[i]) begin
                v = i;
                break;
            end
        end
        if (v < 0) begin
`ifdef GPU_CLUT_LRU_EN
            v = lruQ[0];
`else
            v = rrPtr;
`endif
        end
        rrPtr = (rrPtr + 1) % SLOTS;
        mValid[v] = 1'b0;
        return v;
    endfunction

    function automatic void mFinishFill(int v, int adr, bit is8);
        mValid[v] = 1'b1;
        mAdr[v]   = adr;
        mIs8[v]   = is8;
        mTouch(v);
    endfunction

    function automatic int pktAdr(int adr, int blk);
        return (adr / 64) * 64 + ((adr % 64) + blk) % 64;
    endfunction

    // Full lookup from a negedge; arbiter waits 0..maxWait cycles per packet
    task automatic doLookup(input int adr, input bit is8, input int maxWait, output int gotSlot);
        int  expSlot;
        bit  hit;
        bit  done;
        int  pkts;
        int  blk;
        int  cyc;
        int  waitLeft;
        expSlot = mFindHit(adr, is8);
        hit = (expSlot >= 0);
        if (hit) mTouch(expSlot);
        else expSlot = mStartFill();
        pkts = hit ? 0 : (is8 ? PKT8 : 1);
        i_clutReq    = 1'b1;
        i_clutAdr    = 15'(adr);
        i_clutIs8BPP = is8;
        blk = 0;
        cyc = 0;
        done = 1'b0;
        gotSlot = -1;
        waitLeft = $urandom_range(0, maxWait);
        while (!done && cyc < 300) begin
            @(negedge i_clk);
            cyc++;
            i_memAck = 1'b0;
            if (o_clutAck) begin
                gotSlot = int'(o_clutSlot);
                checkEq("ackSlot", int'(o_clutSlot), expSlot);
                checkEq("pktCount", blk, pkts);
                checkEq("memReqAtAck", int'(o_memReq), 0);
                if (maxWait == 0) checkEq("latency", cyc, pkts + 1);
                i_clutReq = 1'b0;
                done = 1'b1;
            end else if (o_memReq) begin
                checkEq("memAdr", int'(o_memAdr), pktAdr(adr, blk));
                checkEq("wrSlot", int'(o_wrSlot), expSlot);
                checkEq("wrBlock", int'(o_wrBlock), blk);
                checkEq("loading", int'(o_loading), 1);
                if (waitLeft == 0) begin
                    i_memAck = 1'b1;
                    blk++;
                    waitLeft = $urandom_range(0, maxWait);
                end else begin
                    waitLeft--;
                end
            end
        end
        checkEq("lookupDone", int'(done), 1);
        if (done && !hit) mFinishFill(expSlot, adr, is8);
        i_clutReq = 1'b0;
        @(negedge i_clk);
        checkEq("ackPulse", int'(o_clutAck), 0);
    endtask

    // Async reset asserted mid-cycle; outputs must fall without waiting for a clock edge
    task automatic doReset();
        #2;
        i_nrstGPU = 1'b0;
        i_clutReq = 1'b0;
        i_memAck  = 1'b0;
        i_flush   = 1'b0;
        #1;
        checkEq("rstMemReq", int'(o_memReq), 0);
        checkEq("rstLoading", int'(o_loading), 0);
        checkEq("rstAck", int'(o_clutAck), 0);
        checkEq("rstSlot", int'(o_clutSlot), 0);
        checkEq("rstWrSlot", int'(o_wrSlot), 0);
        checkEq("rstWrBlock", int'(o_wrBlock), 0);
        checkEq("rstMemAdr", int'(o_memAdr), 0);
        mReset();
        @(negedge i_clk);
        i_nrstGPU = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        int expE;
        int lastAdr;
        bit lastIs8;
        int adr;
        bit is8;
        int pool [6];
        pool = '{15'h0000, 15'h003F, 15'h7FC1, 15'h1234, 15'h2A3E, 15'h5555};
        lastAdr = 15'h1234;
        lastIs8 = 1'b0;
        mReset();
        repeat (2) @(negedge i_clk);
        doReset();

        // 4bpp miss then hit
        doLookup(15'h1234, 1'b0, 0, s);
        checkEq("firstSlot", s, 0);
        doLookup(15'h1234, 1'b0, 0, s);
        checkEq("hitSlot0", s, 0);

        // 8bpp with X wrap, 4bpp hit on it, 8bpp against a 4bpp-only tag
        doLookup(15'h003C, 1'b1, 0, s);
        checkEq("fill8Slot", s, 1);
        doLookup(15'h003C, 1'b0, 0, s);
        checkEq("hit4on8", s, 1);
        doLookup(15'h1234, 1'b1, 0, s);
        checkEq("reload8Slot", s, 2);
        doLookup(15'h0ABC, 1'b0, 0, s);
        checkEq("fill4thSlot", s, 3);

        // Replacement after touching slot 0
        doLookup(15'h1234, 1'b0, 0, s);
`ifdef GPU_CLUT_LRU_EN
        expE = 1;
`else
        expE = 0;
`endif
        doLookup(15'h7777, 1'b0, 0, s);
        checkEq("victimE", s, expE);

        // Flush during LOAD at block 5, arbiter acks three cycles later
        s = mStartFill();
        i_clutReq = 1'b1;
        i_clutAdr = 15'h0100;
        i_clutIs8BPP = 1'b1;
        for (int b = 0; b < 5; b++) begin
            @(negedge i_clk);
            checkEq("abPreReq", int'(o_memReq), 1);
            checkEq("abPreBlock", int'(o_wrBlock), b);
            i_memAck = 1'b1;
        end
        @(negedge i_clk);
        i_memAck = 1'b0;
        checkEq("abBlock5", int'(o_wrBlock), 5);
        i_flush = 1'b1;
        mFlush();
        for (int k = 1; k <= 3; k++) begin
            @(negedge i_clk);
            i_flush = 1'b0;
            i_memAck = 1'b0;
            checkEq("abMemReq", int'(o_memReq), 1);
            checkEq("abMemAdr", int'(o_memAdr), 15'h0105);
            checkEq("abLoading", int'(o_loading), 0);
            checkEq("abNoAck", int'(o_clutAck), 0);
            if (k == 3) i_memAck = 1'b1;
        end
        @(negedge i_clk);
        i_memAck = 1'b0;
        checkEq("abIdleReq", int'(o_memReq), 0);
        checkEq("abIdleAck", int'(o_clutAck), 0);
        doLookup(15'h0100, 1'b1, 0, s);

        // Flush together with a request for a cached address
        i_clutReq = 1'b1;
        i_clutAdr = 15'h0100;
        i_clutIs8BPP = 1'b0;
        i_flush = 1'b1;
        mFlush();
        @(negedge i_clk);
        i_flush = 1'b0;
        checkEq("flushIdleAck", int'(o_clutAck), 0);
        checkEq("flushIdleReq", int'(o_memReq), 0);
        doLookup(15'h0100, 1'b0, 0, s);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            adr = pool[$urandom_range(0, 5)];
            is8 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                i_clutReq = 1'b1;
                i_clutAdr = 15'(adr);
                i_clutIs8BPP = is8;
                i_flush = 1'b1;
                mFlush();
                @(negedge i_clk);
                i_flush = 1'b0;
                checkEq("rndFlushAck", int'(o_clutAck), 0);
                checkEq("rndFlushReq", int'(o_memReq), 0);
            end
            doLookup(adr, is8, $urandom_range(0, 2), s);
            lastAdr = adr;
            lastIs8 = is8;
        end

        // Async reset in the middle of a fill
        s = mStartFill();
        i_clutReq = 1'b1;
        i_clutAdr = 15'h6000;
        i_clutIs8BPP = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge i_clk);
            checkEq("midReq", int'(o_memReq), 1);
            i_memAck = 1'b1;
        end
        @(negedge i_clk);
        i_memAck = 1'b0;
        checkEq("midLoading", int'(o_loading), 1);
        doReset();
        doLookup(lastAdr, lastIs8, 0, s);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
